// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-reconfigurable clock divider with glitch-free
// start/stop and divisor updates that take effect only at period boundaries.
module clk_div_ctrl #(
  parameter int unsigned W           = 16,
  parameter int unsigned DEFAULT_DIV = 19
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         period_tick,
  output logic [W-1:0] div_active,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [W-1:0] DivReset = W'(DEFAULT_DIV);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] divActive_q, divActive_d;
  logic [W-1:0] pendDiv_q, pendDiv_d;
  logic         pendVld_q, pendVld_d;
  logic         clkOut_q, clkOut_d;
  logic         cfgErr_q, cfgErr_d;

  logic running;
  logic wrap;
  logic goReq;
  logic haltReq;
  logic accept;

  // start and stop raised together cancel each other out
  assign running = (state_q != IDLE);
  assign wrap    = running && (cnt_q == divActive_q);
  assign goReq   = start && !stop;
  assign haltReq = stop && !start;
  assign accept  = cfg_valid && !pendVld_q;

  // Next-state, counter and divisor bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divActive_d = divActive_q;
    pendDiv_d   = pendDiv_q;
    pendVld_d   = pendVld_q;
    cfgErr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (goReq) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        if (haltReq) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        if (goReq) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A held pending divisor becomes active at the boundary, including the
    // final boundary of a stop sequence.
    if (wrap && pendVld_q) begin
      divActive_d = pendDiv_q;
      pendVld_d   = 1'b0;
    end

    // An accept cannot coincide with a pending apply because ready is low
    // whenever a value is pending.
    if (accept) begin
      if (cfg_div == '0) begin
        cfgErr_d = 1'b1;
      end else if (state_q == IDLE) begin
        divActive_d = cfg_div;
      end else begin
        pendDiv_d = cfg_div;
        pendVld_d = 1'b1;
      end
    end

    clkOut_d = (state_d != IDLE) && (cnt_d <= (divActive_d >> 1));
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      divActive_q <= DivReset;
      pendDiv_q   <= '0;
      pendVld_q   <= 1'b0;
      clkOut_q    <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divActive_q <= divActive_d;
      pendDiv_q   <= pendDiv_d;
      pendVld_q   <= pendVld_d;
      clkOut_q    <= clkOut_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign clk_out     = clkOut_q;
  assign period_tick = wrap;
  assign cfg_ready   = !pendVld_q;
  assign cfg_err     = cfgErr_q;
  assign div_active  = divActive_q;
  assign busy        = running;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: the driver steps a behavioural model and
// queues the expected outputs; the monitor pops one entry per clock.
module tb_clk_div_ctrl;

  localparam int W           = 16;
  localparam int DEFAULT_DIV = 19;

  typedef struct packed {
    logic         busy;
    logic         clk;
    logic         tick;
    logic         ready;
    logic         err;
    logic [W-1:0] div;
  } exp_t;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         start;
  logic         stop;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         period_tick;
  logic [W-1:0] div_active;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  exp_t expQ[$];

  // Behavioural model: mode 0 = stopped, 1 = running, 2 = running but
  // stopping at the end of this period; pos is the position in the period.
  int mMode  = 0;
  int mPos   = 0;
  int mDiv   = DEFAULT_DIV;
  int mPend  = 0;
  bit mPendV = 0;
  bit mErr   = 0;

  clk_div_ctrl #(
    .W(W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .div_active (div_active),
    .busy       (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cycle <= cycle + 1;

  // Outputs the model predicts for its current state
  function automatic exp_t modelOutputs();
    exp_t e;
    e.busy  = (mMode != 0);
    e.clk   = e.busy && (mPos < (mDiv / 2 + 1));
    e.tick  = e.busy && (mPos == mDiv);
    e.ready = !mPendV;
    e.err   = mErr;
    e.div   = W'(mDiv);
    return e;
  endfunction

  // Advances the model across one clock edge given the inputs seen there
  task automatic modelStep(input bit rstIn, input bit st, input bit sp,
                           input bit cv, input int cd);
    bit endOfPeriod;
    bit taken;
    if (!rstIn) begin
      mMode  = 0;
      mPos   = 0;
      mDiv   = DEFAULT_DIV;
      mPendV = 0;
      mPend  = 0;
      mErr   = 0;
      return;
    end
    endOfPeriod = (mMode != 0) && (mPos == mDiv);
    taken       = cv && !mPendV;
    mErr        = taken && (cd == 0);
    if (endOfPeriod && mPendV) begin
      mDiv   = mPend;
      mPendV = 0;
    end
    if (taken && cd != 0) begin
      if (mMode == 0) begin
        mDiv = cd;
      end else begin
        mPend  = cd;
        mPendV = 1;
      end
    end
    if (mMode == 0) begin
      mPos = 0;
      if (st && !sp) mMode = 1;
    end else begin
      mPos = endOfPeriod ? 0 : mPos + 1;
      if (mMode == 1) begin
        if (sp && !st) mMode = 2;
      end else begin
        if (st && !sp) begin
          mMode = 1;
        end else if (endOfPeriod) begin
          mMode = 0;
          mPos  = 0;
        end
      end
    end
  endtask

  // Drives one cycle of inputs and queues the predicted response
  task automatic applyStimulus(input bit rstIn, input bit st, input bit sp,
                               input bit cv, input int cd);
    @(negedge sys_clk);
    sys_rst_n = rstIn;
    start     = st;
    stop      = sp;
    cfg_valid = cv;
    cfg_div   = W'(cd);
    modelStep(rstIn, st, sp, cv, cd);
    expQ.push_back(modelOutputs());
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0);
  endtask

  // Compares one observed output bundle against its expectation
  task automatic checkOutput(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got busy=%b clk=%b tick=%b ready=%b err=%b div=%0d want busy=%b clk=%b tick=%b ready=%b err=%b div=%0d",
               name, cycle, got.busy, got.clk, got.tick, got.ready, got.err, got.div,
               want.busy, want.clk, want.tick, want.ready, want.err, want.div);
    end
  endtask

  function automatic exp_t sampleDut();
    exp_t g;
    g.busy  = busy;
    g.clk   = clk_out;
    g.tick  = period_tick;
    g.ready = cfg_ready;
    g.err   = cfg_err;
    g.div   = div_active;
    return g;
  endfunction

  // Monitor: one expectation is consumed shortly after every rising edge
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (expQ.size() > 0) begin
        checkOutput("outputs", sampleDut(), expQ.pop_front());
      end
    end
  end

  initial begin
    exp_t rstExp;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;

    // Reset, then start at the default divisor for two full periods
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(44);

    // Mid-period reconfiguration to a 4-cycle period
    applyStimulus(1, 0, 0, 1, 3);
    idleCycles(50);

    // Back to 20-cycle periods, then stop in the middle of a high phase
    applyStimulus(1, 0, 0, 1, 19);
    idleCycles(30);
    for (int i = 0; i < 40 && mPos != 4; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    idleCycles(25);

    // Zero divisor rejected while stopped and while running
    applyStimulus(1, 0, 0, 1, 0);
    idleCycles(3);
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(5);
    applyStimulus(1, 0, 0, 1, 0);
    idleCycles(5);

    // Stop cancelled by start before the boundary, then a real stop
    applyStimulus(1, 0, 1, 0, 0);
    idleCycles(3);
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(30);
    applyStimulus(1, 0, 1, 0, 0);
    idleCycles(25);

    // Simultaneous start and stop while stopped are ignored
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0);
    idleCycles(3);

    // Odd divisor, then asynchronous reset mid-period with a value pending
    applyStimulus(1, 0, 0, 1, 2);
    applyStimulus(1, 1, 0, 0, 0);
    idleCycles(13);
    applyStimulus(1, 0, 0, 1, 5);
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    rstExp.busy  = 1'b0;
    rstExp.clk   = 1'b0;
    rstExp.tick  = 1'b0;
    rstExp.ready = 1'b1;
    rstExp.err   = 1'b0;
    rstExp.div   = W'(DEFAULT_DIV);
    checkOutput("async_reset", sampleDut(), rstExp);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 0);
    idleCycles(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 6)));
    end
    idleCycles(2);

    @(posedge sys_clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d entries left want 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-reconfigurable clock-divider controller for the sampling clock tree. Generates one divided clock enable/output from `sys_clk`, accepts new divisor values over a valid/ready handshake, and applies them only at a period boundary so the output never produces a runt pulse. It also sequences glitch-free start and stop of the divided clock, such as the AD9226 sample clock, under control of the acquisition logic.

## Interface
- `W`, 16: width of divisor value.
- `DEFAULT_DIV`, 19: `div_active` after reset; period = `DEFAULT_DIV`+1 cycles.

- `sys_clk`, in, 1: system clock (100 MHz).
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: level/pulse request to run the divided clock.
- `stop`, in, 1: request a glitch-free stop at the end of the current period.
- `cfg_valid`, in, 1: new divisor offered.
- `cfg_div`, in, W: divisor minus one (N-1); period = `cfg_div`+1 cycles.
- `cfg_ready`, out, 1: controller can accept a divisor.
- `cfg_err`, out, 1: one-cycle pulse; an accepted `cfg_div` < 1 was discarded.
- `clk_out`, out, 1: divided clock, registered.
- `period_tick`, out, 1: one-cycle pulse on the last cycle of each running period.
- `div_active`, out, W: divisor currently in use.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, STOPPING.
- Counter `cnt` runs 0..`div_active`. It is cleared in IDLE.
- `clk_out` = (state ≠ IDLE) && (`cnt` <= `div_active`>>1). The output is registered together with `cnt`.
  - N=20: 10 cycles high, 10 cycles low.
  - N=3: 2 cycles high, 1 cycle low.
- Wrap occurs in a running state when `cnt` == `div_active`. That cycle drives `period_tick`=1. `cnt` is 0 on the next cycle.
- Transitions:
  - IDLE → RUN on `start`=1 and `stop`=0.
  - RUN → STOPPING on `stop`=1.
  - STOPPING → RUN on `start`=1 and `stop`=0; the stop is cancelled and `cnt` continues.
  - STOPPING → IDLE at wrap.
  - If `stop` is asserted on a wrap cycle in RUN, the state goes to STOPPING and stops at the next wrap.
- `start`=1 and `stop`=1 together: both are ignored in every state.
- Configuration handshake:
  - A transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = !`pend_vld`.
  - `cfg_div` < 1 is discarded: `cfg_err` pulses on the next cycle and no state changes.
  - In IDLE, an accepted value writes `div_active` directly on the next cycle; `pend_vld` stays 0.
  - In RUN/STOPPING, an accepted value loads the pending register and sets `pend_vld`=1.
  - At the next wrap, `div_active` <= pending and `pend_vld` is cleared.
  - A value accepted on a wrap cycle goes into pending. It applies at the following wrap, not the current one.
  - If a period ends in IDLE with a pending value held, the pending value is applied on the transition into IDLE.
- Width: all comparisons are unsigned W-bit. `cnt` never exceeds `div_active`, because changes apply only at wrap.

## Timing
- Reset values (asynchronous):
  - state=IDLE, `cnt`=0, `clk_out`=0, `period_tick`=0, `cfg_err`=0.
  - `div_active`=`DEFAULT_DIV`, `pend_vld`=0, `cfg_ready`=1, `busy`=0.
- Start latency: `start` sampled at edge t → `busy`=1, `cnt`=0 and `clk_out`=1 in cycle t+1.
- Stop latency: `clk_out` stays low from the cycle after the wrap. `busy` falls in the same cycle.
- Config latency:
  - IDLE: `div_active` updates 1 cycle after the handshake.
  - Running: `div_active` updates in the first cycle of the new period.
- `cfg_ready` falls the cycle after a running-state accept. It rises the cycle after the applying wrap.
- Reset mid-period: outputs return to reset values immediately and the pending value is lost.

## Test plan
- Reset, `start` with default 19 → `clk_out` period 20 cycles, 10 high / 10 low; `period_tick` every 20 cycles, on `cnt`=19.
- While running at 19, send `cfg_div`=3 mid-period → `cfg_ready` low; current period completes at 20 cycles, then periods are 4 cycles (2 high / 2 low); `cfg_ready` high again after the wrap.
- `stop` in the middle of a high phase at N=20 → the period completes fully; `busy` and `clk_out` are low after the `cnt`=19 cycle; no pulse shorter than 10 cycles appears.
- `cfg_div`=0 in IDLE and while running → `cfg_err` one-cycle pulse; `div_active` unchanged; `cfg_ready` stays 1.
- `stop` then `start` before the wrap → no gap in `clk_out`; `start`+`stop` together in IDLE → stays IDLE.
- Odd divisor `cfg_div`=2 → period 3 cycles, 2 high / 1 low; `sys_rst_n` asserted mid-period → `clk_out`=0, `div_active`=19 asynchronously.
